sync_fifo_level: RTL and testbench
==================================

// Module: sync_fifo_level
// PURPOSE
//  Single-clock successor to the dual-clock FIFO: same write valid/ready and read valid/ack
//  handshakes, but with no CDC logic. Adds a fill-level output, programmable almost-full and
//  almost-empty flags, a synchronous flush, and first-word-fall-through read data.
//  Used for buffering between bridge, APF and core logic in the same clock domain.
// PARAMETERS
//  address_width       4    depth = 2**address_width entries (min 1)
//  data_width          32   width of each entry
//  almost_full_level   14   almost_full asserts when level >= this value (0..depth)
//  almost_empty_level  2    almost_empty asserts when level <= this value (0..depth)
// PORTS
//  clk           in   1                  single clock, all logic on posedge
//  reset         in   1                  synchronous, active-high
//  flush         in   1                  synchronous clear of contents; memory data is not cleared
//  write_data    in   data_width         data to push
//  write_valid   in   1                  push request
//  write_ready   out  1                  FIFO can accept; push occurs when write_valid && write_ready
//  read_data     out  data_width         head entry; valid while read_valid
//  read_valid    out  1                  head entry present
//  read_ack      in   1                  pop; pop occurs when read_valid && read_ack
//  level         out  address_width+1    entries stored, 0..depth
//  almost_full   out  1                  registered, level >= almost_full_level
//  almost_empty  out  1                  registered, level <= almost_empty_level
// BEHAVIOUR
//  - Reset, while asserted and after deassertion until the first push:
//    level=0, read_valid=0, write_ready=1, almost_full=(almost_full_level==0),
//    almost_empty=1. read_data is don't-care while read_valid=0.
//  - Pointers are address_width+1 bits; the extra bit is the wrap parity.
//    Empty: pointers equal. Full: low bits equal and wrap bit differs. Pointer increments wrap
//    mod 2**(address_width+1).
//  - level counts every accepted, not-yet-popped entry, including one still in the output
//    stage. Next-level arithmetic uses address_width+2 bits; level never exceeds depth.
//  - write_ready = (level != depth) && !flush. It is a function of registered state and flush
//    only; it never depends combinationally on read_ack.
//    When full, a pop in cycle N frees a slot from cycle N+1.
//  - Latency: a word pushed into an empty FIFO at edge N gives read_valid=1 and valid
//    read_data after edge N+1. With read_ack held high, sustained throughput is 1 word/clk
//    with no bubbles.
//  - read_data and read_valid are registered. read_data holds stable while
//    read_valid && !read_ack. read_valid never drops without a pop, except on reset or flush.
//  - Simultaneous push and pop in one cycle: level is unchanged, and both transfers complete.
//  - flush=1 at an edge: pointers and level go to 0 and read_valid goes to 0, exactly as reset.
//    A push or pop in the same cycle is discarded, and read_valid is gated to 0 combinationally
//    while flush=1, so no handshake can complete. Flags update at the same edge.
//  - reset has priority over flush. Reset mid-stream discards all contents, and nothing
//    previously written appears after reset.
//  - almost_full and almost_empty are registered from the next-state level, so they are
//    exact in the same cycle level updates (no extra lag).
//  - Read-before-write to the same memory address cannot occur. The full and empty guards plus
//    the output stage ensure the read never targets the slot being written.
// TESTING (address_width=2, depth=4, almost_full_level=3, almost_empty_level=1)
//  - Reset, then idle -> level=0, read_valid=0, write_ready=1, almost_empty=1, almost_full=0.
//  - Push 0xA1 at edge 0 -> read_valid=1 and read_data=0xA1 after edge 1.
//    Ack it -> level=0 and read_valid=0 the following cycle.
//  - Push 0x10..0x13 with no ack -> level=4, write_ready=0, almost_full=1. A 5th push (0x14) is
//    not accepted. Pop one -> write_ready=1 next cycle. Push 0x14 -> order out is 0x10..0x14.
//  - Push and pop every cycle for 100 cycles from level 2 -> level stays 2,
//    data order preserved, no bubbles on read_valid.
//  - Fill to level 3, assert flush for 1 cycle while write_valid=1 and read_ack=1 ->
//    no transfer completes, level=0, read_valid=0. A subsequent push 0x55 reads back 0x55.
//  - Write-pointer wrap: 10 push/pop rounds through the 4 slots -> all data correct across the
//    wrap-bit toggle. Reset asserted mid-stream -> empty, nothing stale read out.

Source files
------------

// File: rtl/sync_fifo_level.sv
// Single-clock FWFT FIFO with fill level, programmable almost-full/almost-empty flags and
// synchronous flush. A registered output stage holds the head entry; level counts it too.
module sync_fifo_level #(
    parameter int unsigned address_width      = 4,
    parameter int unsigned data_width         = 32,
    parameter int unsigned almost_full_level  = 14,
    parameter int unsigned almost_empty_level = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic [data_width-1:0]   write_data,
    input  logic                    write_valid,
    output logic                    write_ready,
    output logic [data_width-1:0]   read_data,
    input  logic                    read_ack,
    output logic                    read_valid,
    output logic [address_width:0]  level,
    output logic                    almost_full,
    output logic                    almost_empty
);

    localparam int unsigned PTR_W = address_width + 1;
    localparam int unsigned LVL_W = address_width + 2;
    localparam int unsigned DEPTH = 2 ** address_width;

    logic [data_width-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [data_width-1:0] out_data;
    logic                  out_valid;
    logic [LVL_W-1:0]      level_next;
    logic                  push;
    logic                  pop;
    logic                  mem_empty;
    logic                  out_load;

    // Handshakes depend only on registered state and flush, never on read_ack.
    always_comb begin
        write_ready = (level != PTR_W'(DEPTH)) && !flush;
        read_valid  = out_valid && !flush;
        read_data   = out_data;
        push        = write_valid && write_ready;
        pop         = read_valid && read_ack;
        mem_empty   = (wr_ptr == rd_ptr);
        out_load    = !mem_empty && (!out_valid || pop);
        level_next  = '0;
        if (!flush) begin
            level_next = LVL_W'(level) + LVL_W'(push) - LVL_W'(pop);
        end
    end

    // Storage array; contents are not cleared by reset or flush.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[address_width-1:0]] <= write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            out_valid    <= 1'b0;
            level        <= '0;
            almost_full  <= (almost_full_level == 0);
            almost_empty <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            // Refill the output stage whenever it is empty or being popped this cycle.
            if (out_load) begin
                rd_ptr    <= rd_ptr + PTR_W'(1);
                out_valid <= 1'b1;
                out_data  <= mem[rd_ptr[address_width-1:0]];
            end else if (pop) begin
                out_valid <= 1'b0;
            end
            level        <= level_next[address_width:0];
            almost_full  <= (level_next >= LVL_W'(almost_full_level));
            almost_empty <= (level_next <= LVL_W'(almost_empty_level));
        end
    end

endmodule

// File: tb/tb_sync_fifo_level.sv
// Directed self-checking bench for sync_fifo_level (depth 4, almost_full at 3, almost_empty at 1).
module tb_sync_fifo_level;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic [7:0] write_data;
    logic       write_valid;
    logic       write_ready;
    logic [7:0] read_data;
    logic       read_valid;
    logic       read_ack;
    logic [2:0] level;
    logic       almost_full;
    logic       almost_empty;

    int checks   = 0;
    int failures = 0;

    sync_fifo_level #(
        .address_width(2),
        .data_width(8),
        .almost_full_level(3),
        .almost_empty_level(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .flush(flush),
        .write_data(write_data),
        .write_valid(write_valid),
        .write_ready(write_ready),
        .read_data(read_data),
        .read_ack(read_ack),
        .read_valid(read_valid),
        .level(level),
        .almost_full(almost_full),
        .almost_empty(almost_empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [7:0] d);
        write_data  = d;
        write_valid = 1'b1;
        step();
        write_valid = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [7:0] d);
        check({tag, "_rv"}, 32'(read_valid), 32'd1);
        check({tag, "_data"}, 32'(read_data), 32'(d));
        read_ack = 1'b1;
        step();
        read_ack = 1'b0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; write_data = '0; write_valid = 1'b0; read_ack = 1'b0;
        step(); step();
        reset = 1'b0;
        step();
        check("rst_level", 32'(level), 32'd0);
        check("rst_rv", 32'(read_valid), 32'd0);
        check("rst_wr", 32'(write_ready), 32'd1);
        check("rst_ae", 32'(almost_empty), 32'd1);
        check("rst_af", 32'(almost_full), 32'd0);

        // Single word latency and pop
        push_one(8'hA1);
        check("a1_level", 32'(level), 32'd1);
        check("a1_rv_early", 32'(read_valid), 32'd0);
        step();
        check("a1_ae", 32'(almost_empty), 32'd1);
        pop_expect("a1", 8'hA1);
        check("a1_level0", 32'(level), 32'd0);
        check("a1_rv0", 32'(read_valid), 32'd0);

        // Fill to full, rejected push, pop frees a slot
        for (int i = 0; i < 4; i++) push_one(8'(8'h10 + i));
        check("full_level", 32'(level), 32'd4);
        check("full_wr", 32'(write_ready), 32'd0);
        check("full_af", 32'(almost_full), 32'd1);
        check("full_ae", 32'(almost_empty), 32'd0);
        push_one(8'h14);
        check("full_reject_level", 32'(level), 32'd4);
        pop_expect("full_head", 8'h10);
        check("pop_level", 32'(level), 32'd3);
        check("pop_wr", 32'(write_ready), 32'd1);
        push_one(8'h14);
        check("refill_level", 32'(level), 32'd4);
        for (int i = 1; i < 5; i++) pop_expect("order", 8'(8'h10 + i));
        check("order_level", 32'(level), 32'd0);

        // Sustained push+pop from level 2
        push_one(8'h20);
        push_one(8'h21);
        step();
        check("stream_level_start", 32'(level), 32'd2);
        for (int k = 0; k < 100; k++) begin
            write_data  = 8'(8'h22 + k);
            write_valid = 1'b1;
            read_ack    = 1'b1;
            check("stream_rv", 32'(read_valid), 32'd1);
            check("stream_data", 32'(read_data), 32'(8'(8'h20 + k)));
            step();
            check("stream_level", 32'(level), 32'd2);
        end
        write_valid = 1'b0;
        read_ack    = 1'b0;
        pop_expect("stream_tail0", 8'h84);
        pop_expect("stream_tail1", 8'h85);
        check("stream_level_end", 32'(level), 32'd0);

        // Flush with concurrent push and pop attempts
        for (int i = 0; i < 3; i++) push_one(8'(8'h30 + i));
        step();
        check("preflush_level", 32'(level), 32'd3);
        check("preflush_af", 32'(almost_full), 32'd1);
        flush = 1'b1; write_data = 8'h99; write_valid = 1'b1; read_ack = 1'b1;
        #1;
        check("flush_rv_gate", 32'(read_valid), 32'd0);
        check("flush_wr_gate", 32'(write_ready), 32'd0);
        step();
        flush = 1'b0; write_valid = 1'b0; read_ack = 1'b0;
        check("flush_level", 32'(level), 32'd0);
        check("flush_rv", 32'(read_valid), 32'd0);
        check("flush_af", 32'(almost_full), 32'd0);
        check("flush_ae", 32'(almost_empty), 32'd1);
        step(); step();
        check("flush_idle_rv", 32'(read_valid), 32'd0);
        push_one(8'h55);
        step();
        pop_expect("post_flush", 8'h55);
        check("post_flush_level", 32'(level), 32'd0);

        // Pointer wrap across many rounds
        for (int r = 0; r < 10; r++) begin
            push_one(8'(8'hC0 + r));
            step();
            pop_expect("wrap", 8'(8'hC0 + r));
        end
        check("wrap_level", 32'(level), 32'd0);

        // Reset mid-stream discards contents
        for (int i = 0; i < 3; i++) push_one(8'(8'h70 + i));
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_level", 32'(level), 32'd0);
        check("midrst_rv", 32'(read_valid), 32'd0);
        check("midrst_ae", 32'(almost_empty), 32'd1);
        step(); step();
        check("midrst_idle_rv", 32'(read_valid), 32'd0);
        push_one(8'h77);
        step();
        pop_expect("midrst_new", 8'h77);
        check("midrst_end_rv", 32'(read_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
